// File: rtl/ldpc_pkg.sv
// Shared constants, FSM state type and lane helper for the LDPC LLR load path.
package ldpc_pkg;

  localparam int unsigned LLR_WIDTH  = 8;
  localparam int unsigned ROW_WEIGHT = 24;
  localparam int unsigned GF_BASE    = 256;

  localparam int unsigned DataW    = LLR_WIDTH * ROW_WEIGHT;
  localparam int unsigned BeatCntW = $clog2(GF_BASE);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStart,
    StWait
  } feeder_state_e;

  function automatic logic [LLR_WIDTH-1:0] llr_lane(input logic [DataW-1:0] word,
                                                     input int unsigned      k);
    return word[k*LLR_WIDTH +: LLR_WIDTH];
  endfunction

endpackage

// File: rtl/ldpc_llr_feeder.sv
// Loads one frame of GF_BASE LLR beats into the decoder, pulses ini_st for two
// cycles, then holds off the next frame for a fixed decode window.
module ldpc_llr_feeder
  import ldpc_pkg::*;
#(
  parameter int unsigned DEC_CYCLES = 5200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [DataW-1:0] s_data_i,
  input  logic             s_last_i,
  output logic             in_info_wren_o,
  output logic [DataW-1:0] rece_llr_intri_o,
  output logic             ini_st_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             frame_err_o
);

  localparam int unsigned WaitCntW = $clog2(DEC_CYCLES + 1);
  localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(GF_BASE - 1);
  localparam logic [WaitCntW-1:0] LastWait = WaitCntW'(DEC_CYCLES - 1);

  if (DEC_CYCLES == 0) begin : gen_dec_cycles_check
    $fatal(1, "ldpc_llr_feeder: DEC_CYCLES must be non-zero");
  end

  feeder_state_e        state_q;
  logic [BeatCntW-1:0]  beat_cnt_q;
  logic [WaitCntW-1:0]  wait_cnt_q;
  logic [1:0]           st_cnt_q;
  logic                 wren_q;
  logic [DataW-1:0]     llr_q;
  logic                 ini_st_q;
  logic                 frame_done_q;
  logic                 frame_err_q;
  logic                 accept;
  logic                 last_beat;

  assign s_ready_o = (state_q == StLoad) && en_i;
  assign accept    = s_valid_i && s_ready_o;
  assign last_beat = (beat_cnt_q == LastBeat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      st_cnt_q     <= '0;
      wren_q       <= 1'b0;
      llr_q        <= '0;
      ini_st_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (!en_i) begin
      // Frozen: everything holds except the write strobe, which must not repeat a beat.
      wren_q <= 1'b0;
    end else begin
      wren_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StLoad;
        StLoad: begin
          if (accept) begin
            wren_q      <= 1'b1;
            llr_q       <= s_data_i;
            // Frame length is set by the count alone; s_last is only cross-checked.
            frame_err_q <= s_last_i ^ last_beat;
            if (last_beat) begin
              beat_cnt_q <= '0;
              state_q    <= StStart;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        StStart: begin
          if (st_cnt_q == 2'd2) begin
            st_cnt_q <= '0;
            ini_st_q <= 1'b0;
            state_q  <= StWait;
          end else begin
            st_cnt_q <= st_cnt_q + 2'd1;
            ini_st_q <= 1'b1;
          end
        end
        StWait: begin
          if (wait_cnt_q == LastWait) begin
            wait_cnt_q   <= '0;
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_info_wren_o   = wren_q;
  assign rece_llr_intri_o = llr_q;
  assign busy_o           = (state_q != StIdle);
  // Pulses held across a freeze are only shown once enable returns.
  assign ini_st_o         = ini_st_q && en_i;
  assign frame_done_o     = frame_done_q && en_i;
  assign frame_err_o      = frame_err_q && en_i;

  beat_cnt_idle_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StLoad) |-> (beat_cnt_q == '0));

endmodule
